// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing constants.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } uart_state_e;

  localparam int unsigned UART_CLK_HZ      = 25_000_000;
  localparam int unsigned UART_BAUD        = 19_200;
  localparam int unsigned UART_DEFAULT_DIV = UART_CLK_HZ / UART_BAUD;
  localparam int unsigned UART_MIN_DIV     = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// UART bit-timing generator: mid-bit and bit-boundary strobes, bit index and
// frame completion for a programmable divisor and frame length.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int unsigned NB_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load,
  input  logic [NB_W-1:0]  nbits_i,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             tick_mid,
  output logic             tick_edge,
  output logic             frame_done,
  output logic [NB_W-1:0]  bit_idx
);

  uart_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [NB_W-1:0]  nbits_q, nbits_d;
  logic [NB_W-1:0]  bit_idx_d;
  logic             busy_d, tick_mid_d, tick_edge_d, frame_done_d;

  logic [DIV_W-1:0] half_c;
  logic             at_wrap_c;
  logic             at_mid_c;
  logic             last_bit_c;

  assign half_c     = div_q >> 1;
  assign at_wrap_c  = (cnt_q == div_q - DIV_W'(1));
  assign at_mid_c   = (cnt_q == half_c);
  assign last_bit_c = (bit_idx == nbits_q - NB_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides any other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !abort) state_d = RUN;
      RUN: begin
        if (abort)                        state_d = IDLE;
        else if (at_wrap_c && last_bit_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and strobe next values
  always_comb begin
    div_d        = div_q;
    cnt_d        = cnt_q;
    nbits_d      = nbits_q;
    bit_idx_d    = bit_idx;
    tick_mid_d   = 1'b0;
    tick_edge_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = (state_d == RUN);

    unique case (state_q)
      IDLE: begin
        // Divisor is only writable between frames; too-small values are clamped
        if (div_load) begin
          div_d = (div_i < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : div_i;
        end
        if (start && !abort) begin
          nbits_d   = (nbits_i == '0) ? NB_W'(1) : nbits_i;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          tick_mid_d = at_mid_c;
          if (at_wrap_c) begin
            cnt_d       = '0;
            tick_edge_d = 1'b1;
            if (last_bit_c) begin
              frame_done_d = 1'b1;
              bit_idx_d    = '0;
            end else begin
              bit_idx_d = bit_idx + NB_W'(1);
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
      end
      default: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DIV_W'(DEFAULT_DIV);
      cnt_q      <= '0;
      nbits_q    <= NB_W'(1);
      bit_idx    <= '0;
      busy       <= 1'b0;
      tick_mid   <= 1'b0;
      tick_edge  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      nbits_q    <= nbits_d;
      bit_idx    <= bit_idx_d;
      busy       <= busy_d;
      tick_mid   <= tick_mid_d;
      tick_edge  <= tick_edge_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: strobe timing relative to the start edge.
module tb_uart_baud_gen;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned NB_W  = 4;
  localparam int unsigned MAXEV = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] div_i = '0;
  logic             div_load = 1'b0;
  logic [NB_W-1:0]  nbits_i = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, tick_mid, tick_edge, frame_done;
  logic [NB_W-1:0]  bit_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int mid_t [MAXEV];
  int mid_b [MAXEV];
  int edge_t[MAXEV];
  int done_t[MAXEV];
  int n_mid, n_edge, n_done, busy_fall;

  uart_baud_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(1302), .NB_W(NB_W)) dut (
    .clk(clk), .rst_n(rst_n), .div_i(div_i), .div_load(div_load),
    .nbits_i(nbits_i), .start(start), .abort(abort), .busy(busy),
    .tick_mid(tick_mid), .tick_edge(tick_edge), .frame_done(frame_done),
    .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_div(input int d);
    @(negedge clk);
    div_i    = DIV_W'(d);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  // Start a frame (sampled at E0) and log strobe times relative to E0 for span cycles.
  task automatic run_frame(input int nb, input int span, input int abort_rel, input int ign_rel);
    int e0;
    logic prev_busy;
    n_mid = 0; n_edge = 0; n_done = 0; busy_fall = -1;
    nbits_i = NB_W'(nb);
    start   = 1'b1;
    @(negedge clk);
    e0 = cyc;
    start = 1'b0;
    prev_busy = busy;
    check("busy_at_e0", int'(busy), 1);
    for (int r = 1; r <= span; r++) begin
      abort    = (r == abort_rel);
      start    = (r == ign_rel);
      div_load = (r == ign_rel);
      div_i    = DIV_W'(10);
      @(negedge clk);
      abort = 1'b0; start = 1'b0; div_load = 1'b0;
      if (tick_mid && n_mid < MAXEV) begin
        mid_t[n_mid] = cyc - e0;
        mid_b[n_mid] = int'(bit_idx);
        n_mid++;
      end
      if (tick_edge && n_edge < MAXEV) begin edge_t[n_edge] = cyc - e0; n_edge++; end
      if (frame_done && n_done < MAXEV) begin done_t[n_done] = cyc - e0; n_done++; end
      if (prev_busy && !busy && busy_fall < 0) busy_fall = cyc - e0;
      prev_busy = busy;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_tick_mid", int'(tick_mid), 0);
    check("rst_tick_edge", int'(tick_edge), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_bit_idx", int'(bit_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default divisor 1302, N=1
    run_frame(1, 1310, 0, 0);
    check("def_n_mid", n_mid, 1);
    check("def_mid0", mid_t[0], 652);
    check("def_n_edge", n_edge, 1);
    check("def_edge0", edge_t[0], 1302);
    check("def_n_done", n_done, 1);
    check("def_done0", done_t[0], 1302);
    check("def_fall", busy_fall, 1302);
    check("def_busy_after", int'(busy), 0);

    // D=4, N=2
    load_div(4);
    run_frame(2, 12, 0, 0);
    check("small_n_mid", n_mid, 2);
    check("small_mid0", mid_t[0], 3);
    check("small_mid1", mid_t[1], 7);
    check("small_bidx0", mid_b[0], 0);
    check("small_bidx1", mid_b[1], 1);
    check("small_n_edge", n_edge, 2);
    check("small_edge0", edge_t[0], 4);
    check("small_edge1", edge_t[1], 8);
    check("small_n_done", n_done, 1);
    check("small_done0", done_t[0], 8);
    check("small_fall", busy_fall, 8);
    check("small_bidx_end", int'(bit_idx), 0);

    // Odd divisor D=5
    load_div(5);
    run_frame(1, 8, 0, 0);
    check("odd_mid0", mid_t[0], 3);
    check("odd_edge0", edge_t[0], 5);
    check("odd_n_edge", n_edge, 1);

    // D=1 clamps to 2
    load_div(1);
    run_frame(1, 6, 0, 0);
    check("clamp_n_mid", n_mid, 1);
    check("clamp_mid0", mid_t[0], 2);
    check("clamp_edge0", edge_t[0], 2);
    check("clamp_done0", done_t[0], 2);
    check("clamp_n_edge", n_edge, 1);

    // Abort sampled at E0+7 while the bit-1 mid strobe is due
    load_div(4);
    run_frame(3, 14, 7, 0);
    check("abort_fall", busy_fall, 7);
    check("abort_n_mid", n_mid, 1);
    check("abort_n_edge", n_edge, 1);
    check("abort_edge0", edge_t[0], 4);
    check("abort_n_done", n_done, 0);
    check("abort_bidx", int'(bit_idx), 0);

    // start/div_load during RUN are ignored
    run_frame(2, 10, 0, 2);
    check("ign_n_edge", n_edge, 2);
    check("ign_edge0", edge_t[0], 4);
    check("ign_edge1", edge_t[1], 8);
    check("ign_mid1", mid_t[1], 7);
    check("ign_done0", done_t[0], 8);
    run_frame(1, 6, 0, 0);
    check("ign_next_edge0", edge_t[0], 4);
    check("ign_next_n_edge", n_edge, 1);

    // N=0 behaves as one bit
    run_frame(0, 6, 0, 0);
    check("n0_n_done", n_done, 1);
    check("n0_done0", done_t[0], 4);

    // Back-to-back: second start lands on the cycle after busy falls
    run_frame(1, 4, 0, 0);
    check("b2b0_edge0", edge_t[0], 4);
    check("b2b0_fall", busy_fall, 4);
    run_frame(1, 6, 0, 0);
    check("b2b1_n_mid", n_mid, 1);
    check("b2b1_mid0", mid_t[0], 3);
    check("b2b1_n_edge", n_edge, 1);
    check("b2b1_edge0", edge_t[0], 4);
    check("b2b1_done0", done_t[0], 4);

    // Reset mid-frame: immediate return to IDLE, divisor back to default
    nbits_i = NB_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_bit_idx", int'(bit_idx), 0);
    check("mrst_tick_edge", int'(tick_edge), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(1, 660, 0, 0);
    check("mrst_def_mid0", mid_t[0], 652);
    check("mrst_def_n_edge", n_edge, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
